time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_alarm_pkg.sv | 28 ++
 rtl/alarm_ctrl.sv | 90 +++++++++
 rtl/time_keeper.sv | 115 +++++++++++
 3 files changed

// File: rtl/clock_alarm_pkg.sv
// Shared types and constants for the clock/alarm slice: alarm FSM state,
// time field limits, reset values and the set-value legality check.
package clock_alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_ACKED   = 2'd2
   } alarm_state_e;

   localparam logic [5:0] MAX_SECS    = 6'd59;
   localparam logic [5:0] MAX_MINS    = 6'd59;
   localparam logic [3:0] MAX_HOURS   = 4'd12;

   // Power-on time 12:00:00 AM, power-on alarm 06:00 AM
   localparam logic [3:0] RST_HOURS   = 4'd12;
   localparam logic [5:0] RST_MINS    = 6'd0;
   localparam logic       RST_PM      = 1'b0;
   localparam logic [3:0] RST_A_HOURS = 4'd6;
   localparam logic [5:0] RST_A_MINS  = 6'd0;
   localparam logic       RST_A_PM    = 1'b0;

   // A set value is usable only if hours is 1..12 and minutes is 0..59
   function automatic logic set_is_legal(input logic [3:0] hours, input logic [5:0] mins);
      return (hours != 4'd0) && (hours <= MAX_HOURS) && (mins <= MAX_MINS);
   endfunction

endpackage

// File: rtl/alarm_ctrl.sv
// Alarm sequencing: waits for a time match, rings until acknowledged or
// timed out, then stays quiet until the matching minute has passed.
module alarm_ctrl
   import clock_alarm_pkg::*;
#(
   parameter int ALARM_TIMEOUT_S = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic match,
   input  logic tick,
   input  logic stop_alarm,
   input  logic alarm_en,
   output logic alarm
);

   localparam int CNT_W = $clog2(ALARM_TIMEOUT_S + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(ALARM_TIMEOUT_S);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   alarm_state_e     state_r;
   logic [CNT_W-1:0] ring_cnt_r;
   logic [CNT_W-1:0] ring_cnt_inc_s;
   logic             alarm_r;

   assign ring_cnt_inc_s = ring_cnt_r + CNT_ONE;

   // Alarm FSM with ring counter; alarm_r is set exactly when the next state is RINGING
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ring_cnt_r <= CNT_ZERO;
         alarm_r    <= 1'b0;
      end else if (!alarm_en) begin
         // Disarming wins over everything and returns to a clean idle
         state_r    <= ST_IDLE;
         ring_cnt_r <= CNT_ZERO;
         alarm_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ring_cnt_r <= CNT_ZERO;
               if (match) begin
                  state_r <= ST_RINGING;
                  alarm_r <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  alarm_r <= 1'b0;
               end
            end
            ST_RINGING: begin
               if (stop_alarm) begin
                  state_r <= ST_ACKED;
                  alarm_r <= 1'b0;
               end else if (tick) begin
                  ring_cnt_r <= ring_cnt_inc_s;
                  if (ring_cnt_inc_s >= TIMEOUT_C) begin
                     state_r <= ST_ACKED;
                     alarm_r <= 1'b0;
                  end else begin
                     state_r <= ST_RINGING;
                     alarm_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_RINGING;
                  alarm_r <= 1'b1;
               end
            end
            ST_ACKED: begin
               // Hold off until the matching minute is over so it cannot retrigger
               alarm_r <= 1'b0;
               if (!match) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ACKED;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               ring_cnt_r <= CNT_ZERO;
               alarm_r    <= 1'b0;
            end
         endcase
      end
   end

   assign alarm = alarm_r;

endmodule

// File: rtl/time_keeper.sv
// 12-hour alarm clock: seconds/minutes/hours counter with AM/PM, loadable
// alarm register, display mux and the alarm sequencer.
module time_keeper
   import clock_alarm_pkg::*;
#(
   parameter int ALARM_TIMEOUT_S = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_sec_tick,
   input  logic       load_time,
   input  logic       load_alarm,
   input  logic [3:0] set_hours,
   input  logic [5:0] set_mins,
   input  logic       set_pm,
   input  logic       alarm_en,
   input  logic       stop_alarm,
   input  logic       show_alarm,
   output logic [3:0] hours_cur,
   output logic [5:0] mins_cur,
   output logic       pm,
   output logic       alarm
);

   logic [5:0] secs_r;
   logic [5:0] mins_r;
   logic [3:0] hours_r;
   logic       pm_r;
   logic [3:0] a_hours_r;
   logic [5:0] a_mins_r;
   logic       a_pm_r;
   logic       set_legal_s;
   logic       match_s;

   assign set_legal_s = set_is_legal(set_hours, set_mins);

   // Current time: a legal load beats a coincident tick; otherwise count seconds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         secs_r  <= 6'd0;
         mins_r  <= RST_MINS;
         hours_r <= RST_HOURS;
         pm_r    <= RST_PM;
      end else if (load_time && set_legal_s) begin
         secs_r  <= 6'd0;
         mins_r  <= set_mins;
         hours_r <= set_hours;
         pm_r    <= set_pm;
      end else if (one_sec_tick) begin
         if (secs_r == MAX_SECS) begin
            secs_r <= 6'd0;
            if (mins_r == MAX_MINS) begin
               mins_r <= 6'd0;
               if (hours_r == MAX_HOURS) begin
                  hours_r <= 4'd1;
               end else begin
                  hours_r <= hours_r + 4'd1;
                  // 11:59:59 -> 12:00:00 is where AM and PM swap
                  if (hours_r == 4'd11) begin
                     pm_r <= ~pm_r;
                  end
               end
            end else begin
               mins_r <= mins_r + 6'd1;
            end
         end else begin
            secs_r <= secs_r + 6'd1;
         end
      end
   end

   // Alarm register: takes legal set values, otherwise holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_hours_r <= RST_A_HOURS;
         a_mins_r  <= RST_A_MINS;
         a_pm_r    <= RST_A_PM;
      end else if (load_alarm && set_legal_s) begin
         a_hours_r <= set_hours;
         a_mins_r  <= set_mins;
         a_pm_r    <= set_pm;
      end
   end

   assign match_s = alarm_en && (hours_r == a_hours_r) && (mins_r == a_mins_r) && (pm_r == a_pm_r);

   // Display source select between alarm setting and current time
   always_comb begin
      hours_cur = hours_r;
      mins_cur  = mins_r;
      pm        = pm_r;
      if (show_alarm) begin
         hours_cur = a_hours_r;
         mins_cur  = a_mins_r;
         pm        = a_pm_r;
      end else begin
         hours_cur = hours_r;
         mins_cur  = mins_r;
         pm        = pm_r;
      end
   end

   alarm_ctrl #(
      .ALARM_TIMEOUT_S(ALARM_TIMEOUT_S)
   ) u_alarm_ctrl (
      .clk       (clk),
      .reset     (reset),
      .match     (match_s),
      .tick      (one_sec_tick),
      .stop_alarm(stop_alarm),
      .alarm_en  (alarm_en),
      .alarm     (alarm)
   );

endmodule
